i2c_fifo_tx_sched: RTL and testbench



---
 rtl/i2c_fifo_tx_sched_if.sv | 40 ++++
 rtl/i2c_fifo_tx_sched.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_fifo_tx_sched.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_fifo_tx_sched_if.sv
// FIFO read port and I2C byte-engine command port.
// master = scheduler side, slave = FIFO/engine side.
interface i2c_fifo_tx_sched_if;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_vld;
  logic       fifo_rd_empty;
  logic [1:0] eng_cmd;
  logic [7:0] eng_data;
  logic       eng_cmd_vld;
  logic       eng_ready;
  logic       eng_done;
  logic       eng_ack;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_vld,
    input  fifo_rd_empty,
    output eng_cmd,
    output eng_data,
    output eng_cmd_vld,
    input  eng_ready,
    input  eng_done,
    input  eng_ack
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_vld,
    output fifo_rd_empty,
    input  eng_cmd,
    input  eng_data,
    input  eng_cmd_vld,
    output eng_ready,
    output eng_done,
    output eng_ack
  );
endinterface

// File: rtl/i2c_fifo_tx_sched.sv
// I2C write scheduler: START, address, N FIFO bytes, STOP.
// Aborts on NACK or FIFO underflow; every output is registered.
module i2c_fifo_tx_sched #(
  parameter int LSIZE     = 8,
  parameter int TO_CYCLES = 1000,
  parameter int TO_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_req,
  input  logic [6:0]       dev_addr,
  input  logic [LSIZE-1:0] byte_len,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [LSIZE-1:0] sent_cnt,
  i2c_fifo_tx_sched_if.master bus
);

  localparam logic [1:0] C_IDLE  = 2'b00;
  localparam logic [1:0] C_START = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;

  localparam bit TO_EN = (TO_CYCLES != 0);
  localparam int TO_LAST_I =
    (TO_CYCLES > 0) ? TO_CYCLES - 1 : 0;
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'(TO_LAST_I);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_CMD,
    S_START_WAIT,
    S_ADDR_CMD,
    S_ADDR_WAIT,
    S_FETCH,
    S_LOAD,
    S_DATA_CMD,
    S_DATA_WAIT,
    S_STOP_CMD,
    S_STOP_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [6:0]          addr_q, addr_d;
  logic [LSIZE-1:0]    len_q, len_d;
  logic [LSIZE-1:0]    rem_q, rem_d;
  logic [TO_WIDTH-1:0] to_q, to_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          err_q, err_d;
  logic [LSIZE-1:0]    sent_q, sent_d;
  logic                rd_q, rd_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [7:0]          data_q, data_d;
  logic                vld_q, vld_d;
  logic                xfer;

  assign xfer = vld_q && bus.eng_ready;

  assign busy            = busy_q;
  assign done            = done_q;
  assign err_code        = err_q;
  assign sent_cnt        = sent_q;
  assign bus.fifo_rd_en  = rd_q;
  assign bus.eng_cmd     = cmd_q;
  assign bus.eng_data    = data_q;
  assign bus.eng_cmd_vld = vld_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      to_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 2'd0;
      sent_q  <= '0;
      rd_q    <= 1'b0;
      cmd_q   <= C_IDLE;
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sent_q  <= sent_d;
      rd_q    <= rd_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    rem_d   = rem_q;
    to_d    = to_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    sent_d  = sent_q;
    rd_d    = 1'b0;
    cmd_d   = cmd_q;
    data_d  = data_q;
    vld_d   = vld_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          addr_d  = dev_addr;
          len_d   = byte_len;
          rem_d   = byte_len;
          sent_d  = '0;
          err_d   = 2'd0;
          to_d    = '0;
          busy_d  = 1'b1;
          cmd_d   = C_START;
          data_d  = 8'h00;
          vld_d   = 1'b1;
          state_d = S_START_CMD;
        end
      end
      S_START_CMD, S_ADDR_CMD, S_STOP_CMD: begin
        if (xfer) begin
          vld_d  = 1'b0;
          cmd_d  = C_IDLE;
          data_d = 8'h00;
          unique case (state_q)
            S_START_CMD: state_d = S_START_WAIT;
            S_ADDR_CMD:  state_d = S_ADDR_WAIT;
            default:     state_d = S_STOP_WAIT;
          endcase
        end
      end
      S_DATA_CMD: begin
        // First cycle raises valid on the byte captured in LOAD.
        if (!vld_q) begin
          vld_d = 1'b1;
          cmd_d = C_WRITE;
        end else if (bus.eng_ready) begin
          vld_d   = 1'b0;
          cmd_d   = C_IDLE;
          data_d  = 8'h00;
          state_d = S_DATA_WAIT;
        end
      end
      S_START_WAIT: begin
        if (bus.eng_done) begin
          cmd_d   = C_WRITE;
          data_d  = {addr_q, 1'b0};
          vld_d   = 1'b1;
          state_d = S_ADDR_CMD;
        end
      end
      S_ADDR_WAIT: begin
        if (bus.eng_done) begin
          if (bus.eng_ack || len_q == '0) begin
            if (bus.eng_ack) err_d = 2'd1;
            cmd_d   = C_STOP;
            data_d  = 8'h00;
            vld_d   = 1'b1;
            state_d = S_STOP_CMD;
          end else begin
            to_d    = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (!bus.fifo_rd_empty) begin
          rd_d    = 1'b1;
          to_d    = '0;
          state_d = S_LOAD;
        end else if (TO_EN && to_q == TO_LAST) begin
          err_d   = 2'd3;
          to_d    = '0;
          cmd_d   = C_STOP;
          data_d  = 8'h00;
          vld_d   = 1'b1;
          state_d = S_STOP_CMD;
        end else begin
          to_d = to_q + TO_WIDTH'(1);
        end
      end
      S_LOAD: begin
        if (bus.fifo_rd_vld) begin
          data_d  = bus.fifo_rd_data;
          state_d = S_DATA_CMD;
        end
      end
      S_DATA_WAIT: begin
        if (bus.eng_done) begin
          if (bus.eng_ack) begin
            err_d   = 2'd2;
            cmd_d   = C_STOP;
            data_d  = 8'h00;
            vld_d   = 1'b1;
            state_d = S_STOP_CMD;
          end else begin
            if (sent_q != len_q) sent_d = sent_q + LSIZE'(1);
            if (rem_q != '0) rem_d = rem_q - LSIZE'(1);
            if (rem_q <= LSIZE'(1)) begin
              cmd_d   = C_STOP;
              data_d  = 8'h00;
              vld_d   = 1'b1;
              state_d = S_STOP_CMD;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
      end
      S_STOP_WAIT: begin
        if (bus.eng_done) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_fifo_tx_sched.sv
// Bench for i2c_fifo_tx_sched: FIFO and engine models,
// a vector table of transactions, plus timing sequences.
module tb_i2c_fifo_tx_sched;

  logic       clk;
  logic       rst;
  logic       start_req;
  logic [6:0] dev_addr;
  logic [7:0] byte_len;
  logic       busy;
  logic       done;
  logic [1:0] err_code;
  logic [7:0] sent_cnt;

  i2c_fifo_tx_sched_if bus ();

  i2c_fifo_tx_sched #(
    .LSIZE(8),
    .TO_CYCLES(16),
    .TO_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_req(start_req),
    .dev_addr(dev_addr),
    .byte_len(byte_len),
    .busy(busy),
    .done(done),
    .err_code(err_code),
    .sent_cnt(sent_cnt),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic [9:0] log[$];
  int  pops_total = 0;
  int  nack_idx = -1;
  bit  ready_en = 1'b1;

  logic [1:0] pend;
  logic       ack_q;
  int         wr_num;

  assign bus.eng_ready = ready_en;

  // FIFO model: one-cycle read latency.
  always @(posedge clk) begin
    bus.fifo_rd_vld <= 1'b0;
    if (!rst && bus.fifo_rd_en) begin
      pops_total <= pops_total + 1;
      if (q.size() > 0) begin
        bus.fifo_rd_data <= q.pop_front();
        bus.fifo_rd_vld  <= 1'b1;
      end
    end
  end

  always @(negedge clk)
    bus.fifo_rd_empty <= (q.size() == 0);

  // Engine model: done two cycles after accept.
  always @(posedge clk) begin
    bus.eng_done <= 1'b0;
    bus.eng_ack  <= 1'b0;
    if (rst) begin
      pend  <= 2'd0;
      ack_q <= 1'b0;
    end else begin
      if (pend == 2'd1) begin
        bus.eng_done <= 1'b1;
        bus.eng_ack  <= ack_q;
      end
      if (pend != 2'd0) pend <= pend - 2'd1;
      if (bus.eng_cmd_vld && bus.eng_ready) begin
        log.push_back({bus.eng_cmd, bus.eng_data});
        pend <= 2'd2;
        ack_q <= 1'b0;
        if (bus.eng_cmd == 2'b01) begin
          wr_num <= 0;
        end else if (bus.eng_cmd == 2'b10) begin
          ack_q  <= (wr_num == nack_idx);
          wr_num <= wr_num + 1;
        end
      end
    end
  end

  typedef struct packed {
    logic [6:0]  addr;
    logic [7:0]  len;
    int          nfifo;
    logic [31:0] bytes;
    int          nack;
    logic [1:0]  err;
    logic [7:0]  sent;
    int          pops;
  } vec_t;

  vec_t vt[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic preload(input vec_t v);
    q.delete();
    for (int i = 0; i < v.nfifo; i++)
      q.push_back(v.bytes[8*i +: 8]);
    nack_idx = v.nack;
    tick();
  endtask

  task automatic run(input vec_t v, input bit poke);
    int bl, bp, nwr, nd;
    bit got;
    logic [9:0] e;
    preload(v);
    bl = log.size();
    bp = pops_total;
    dev_addr  = v.addr;
    byte_len  = v.len;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    check("acc_busy", busy, 1);
    check("acc_cmd", {bus.eng_cmd_vld, bus.eng_cmd}, 3'b101);
    if (poke) begin
      tick();
      dev_addr  = 7'h11;
      byte_len  = 8'd9;
      start_req = 1'b1;
      tick();
      start_req = 1'b0;
    end
    wait_done(got);
    check("done_seen", got, 1);
    check("err", err_code, v.err);
    check("sent", sent_cnt, v.sent);
    check("busy_end", busy, 0);
    tick();
    check("done_pulse", done, 0);
    check("not_queued", busy, 0);
    check("err_hold", err_code, v.err);
    check("pops", pops_total - bp, v.pops);
    if (v.nack >= 0) begin
      nwr = v.nack + 1;
    end else begin
      nd  = (int'(v.len) < v.nfifo) ? int'(v.len) : v.nfifo;
      nwr = nd + 1;
    end
    check("log_len", log.size() - bl, nwr + 2);
    if (log.size() - bl == nwr + 2) begin
      check("log_start", log[bl], {2'b01, 8'h00});
      for (int k = 0; k < nwr; k++) begin
        if (k == 0) e = {2'b10, v.addr, 1'b0};
        else e = {2'b10, v.bytes[8*(k-1) +: 8]};
        check("log_write", log[bl+1+k], e);
      end
      check("log_stop", log[bl+nwr+1], {2'b11, 8'h00});
    end
  endtask

  initial begin
    bit got;
    int bl, bp, lat;
    vec_t v;

    vt[0] = '{7'h50, 8'd3, 3, 32'h00FF3CA5, -1, 2'd0, 8'd3, 3};
    vt[1] = '{7'h2A, 8'd2, 2, 32'h00001234, 0, 2'd1, 8'd0, 0};
    vt[2] = '{7'h13, 8'd4, 4, 32'h44332211, 2, 2'd2, 8'd1, 2};
    vt[3] = '{7'h7F, 8'd2, 1, 32'h0000005A, -1, 2'd3, 8'd1, 1};
    vt[4] = '{7'h00, 8'd0, 0, 32'h00000000, -1, 2'd0, 8'd0, 0};
    vt[5] = '{7'h61, 8'd1, 1, 32'h000000C3, -1, 2'd0, 8'd1, 1};
    vt[6] = '{7'h33, 8'd2, 2, 32'h00009966, 1, 2'd2, 8'd0, 1};

    rst       = 1'b1;
    start_req = 1'b0;
    dev_addr  = 7'h00;
    byte_len  = 8'd0;
    tick();
    tick();
    check("rst_out",
          {busy, done, err_code, sent_cnt, bus.fifo_rd_en,
           bus.eng_cmd, bus.eng_data, bus.eng_cmd_vld}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run(vt[i], i == 0);

    // Underflow right after the address: STOP 16 cycles into FETCH.
    v = '{7'h44, 8'd1, 0, 32'h0, -1, 2'd3, 8'd0, 0};
    preload(v);
    bl = log.size();
    bp = pops_total;
    dev_addr  = v.addr;
    byte_len  = v.len;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.eng_done && log.size() == bl + 2) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("uf_addr_done", got, 1);
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      lat++;
      if (bus.eng_cmd_vld && bus.eng_cmd == 2'b11) begin
        got = 1'b1;
        break;
      end
    end
    check("uf_stop_seen", got, 1);
    check("uf_latency", lat, 17);
    wait_done(got);
    check("uf_done", got, 1);
    check("uf_err", err_code, 2'd3);
    check("uf_sent", sent_cnt, 0);
    check("uf_pops", pops_total - bp, 0);
    tick();

    // Engine stalls 5 cycles on the address byte.
    v = '{7'h5C, 8'd1, 1, 32'h000000E7, -1, 2'd0, 8'd1, 1};
    preload(v);
    dev_addr  = v.addr;
    byte_len  = v.len;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    tick();
    ready_en = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus.eng_cmd_vld) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("stall_vld", got, 1);
    for (int c = 0; c < 5; c++) begin
      check("stall_hold",
            {bus.eng_cmd_vld, bus.eng_cmd, bus.eng_data},
            {1'b1, 2'b10, 7'h5C, 1'b0});
      tick();
    end
    ready_en = 1'b1;
    wait_done(got);
    check("stall_done", got, 1);
    check("stall_err", err_code, 2'd0);
    check("stall_sent", sent_cnt, 1);
    tick();

    // Reset while waiting on the first data byte.
    v = '{7'h21, 8'd2, 2, 32'h00007788, -1, 2'd0, 8'd2, 2};
    preload(v);
    bl = log.size();
    dev_addr  = v.addr;
    byte_len  = v.len;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (log.size() == bl + 3) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("mid_reach", got, 1);
    rst = 1'b1;
    tick();
    check("mid_busy", busy, 0);
    check("mid_out",
          {busy, done, err_code, sent_cnt, bus.fifo_rd_en,
           bus.eng_cmd, bus.eng_data, bus.eng_cmd_vld}, 0);
    rst = 1'b0;
    q.delete();
    tick();
    run('{7'h0F, 8'd1, 1, 32'h0000004D, -1, 2'd0, 8'd1, 1}, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
